// File: rtl/membus_arbiter.sv
// Two-master (ibus/dbus) to one-slave memory arbiter with dbus-priority anti-starvation streak
// limit, registered slave request, one-cycle ready pulse and a bus-timeout watchdog.
module membus_arbiter #(
    parameter int unsigned   AW          = 32,
    parameter int unsigned   DW          = 32,
    parameter int unsigned   MW          = 4,
    parameter int unsigned   MAX_STREAK  = 4,
    parameter int unsigned   TIMEOUT_CYC = 255,
    parameter logic [DW-1:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    input  logic [MW-1:0] i_mask,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [MW-1:0] d_mask,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          s_req,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    output logic [MW-1:0] s_mask,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_ready,
    output logic          o_err
);

    localparam int unsigned SW = $clog2(MAX_STREAK + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            s_we_q, s_we_d;
    logic [AW-1:0]   s_addr_q, s_addr_d;
    logic [DW-1:0]   s_wdata_q, s_wdata_d;
    logic [MW-1:0]   s_mask_q, s_mask_d;
    logic            owner_q, owner_d;  // 1: dbus owns the access
    logic [SW-1:0]   streak_q, streak_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_q, err_d;
    logic [DW-1:0]   i_rdata_q, i_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;

    logic            any_req;
    logic            grant_d;
    logic            timeout;
    logic            done;
    logic [DW-1:0]   resp_data;

    // dbus has priority until it has won MAX_STREAK times in a row against a waiting ibus.
    assign any_req   = i_req | d_req;
    assign grant_d   = d_req & ~(i_req & (streak_q == SW'(MAX_STREAK)));
    assign timeout   = (tmo_q == TW'(TIMEOUT_CYC - 1));
    assign done      = s_ready | timeout;
    assign resp_data = s_ready ? s_rdata : ERR_DATA;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StBusy;
            StBusy:  if (done) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s_req   = (state_q == StBusy);
        i_ready = (state_q == StResp) & ~owner_q;
        d_ready = (state_q == StResp) & owner_q;
        o_err   = (state_q == StResp) & err_q;
        s_we    = s_we_q;
        s_addr  = s_addr_q;
        s_wdata = s_wdata_q;
        s_mask  = s_mask_q;
        i_rdata = i_rdata_q;
        d_rdata = d_rdata_q;
    end

    always_comb begin
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_mask_d  = s_mask_q;
        owner_d   = owner_q;
        streak_d  = streak_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    owner_d = grant_d;
                    if (grant_d) begin
                        s_we_d    = d_we;
                        s_addr_d  = d_addr;
                        s_wdata_d = d_wdata;
                        s_mask_d  = d_mask;
                        if (!i_req) begin
                            streak_d = '0;
                        end else if (streak_q != SW'(MAX_STREAK)) begin
                            streak_d = streak_q + SW'(1);
                        end
                    end else begin
                        s_we_d    = i_we;
                        s_addr_d  = i_addr;
                        s_wdata_d = i_wdata;
                        s_mask_d  = i_mask;
                        streak_d  = '0;
                    end
                end
            end
            StBusy: begin
                tmo_d = tmo_q + TW'(1);
                if (done) begin
                    err_d = ~s_ready;
                    if (owner_q) begin
                        d_rdata_d = resp_data;
                    end else begin
                        i_rdata_d = resp_data;
                    end
                end
            end
            StResp: begin
                tmo_d = '0;
                err_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_mask_q  <= '0;
            owner_q   <= 1'b0;
            streak_q  <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_mask_q  <= s_mask_d;
            owner_q   <= owner_d;
            streak_q  <= streak_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// Bench for membus_arbiter: directed scenarios followed by a random run checked against a
// transaction-level timing/arbitration model.
module tb_membus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0, i_we = 1'b0;
    logic [31:0] i_addr = '0, i_wdata = '0;
    logic [3:0]  i_mask = '0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [3:0]  d_mask = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        s_req, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_mask;
    logic [31:0] s_rdata = '0;
    logic        s_ready = 1'b0;
    logic        o_err;

    membus_arbiter #(
        .AW(32), .DW(32), .MW(4), .MAX_STREAK(4), .TIMEOUT_CYC(255), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_mask(i_mask),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_mask(s_mask),
        .s_rdata(s_rdata), .s_ready(s_ready), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          slave_lat = 0;     // BUSY cycle index of s_ready; -1 never answers
    logic [31:0] slave_data = '0;
    bit          noise = 1'b0;      // random s_ready/s_rdata while slave not selected
    int          busy_cyc = 0;
    logic        prev_sreq = 1'b0;
    logic        sreq_rise = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge and drive the slave for the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        sreq_rise = s_req & ~prev_sreq;
        if (s_req) busy_cyc = prev_sreq ? busy_cyc + 1 : 0;
        prev_sreq = s_req;
        if (s_req) begin
            s_ready = (slave_lat >= 0) && (busy_cyc == slave_lat);
            s_rdata = slave_data;
        end else begin
            s_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            s_rdata = $urandom();
        end
    endtask

    task automatic drive_i(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] m);
        i_req = 1'b1; i_we = we; i_addr = a; i_wdata = wd; i_mask = m;
    endtask

    task automatic drive_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] m);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_mask = m;
    endtask

    task automatic wait_ready(input bit want_d, output int busy, output bit ok);
        busy = 0;
        ok   = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            step();
            if (s_req) busy++;
            if (want_d ? d_ready : i_ready) ok = 1'b1;
        end
    endtask

    // Both masters hold requests (ibus at 0x1000, dbus at 0x2000); grant order must follow
    // the streak rule starting from an empty streak.
    task automatic check_grants(input string tag, input int n);
        int          st;
        int          got;
        logic [31:0] ea;
        st  = 0;
        got = 0;
        for (int k = 0; k < 8 * n && got < n; k++) begin
            step();
            chk({tag, "_excl"}, 64'(i_ready & d_ready), 64'd0);
            if (sreq_rise) begin
                ea = (st == 4) ? 32'h1000 : 32'h2000;
                st = (st == 4) ? 0 : st + 1;
                chk($sformatf("%s_grant%0d", tag, got), 64'(s_addr), 64'(ea));
                got++;
            end
        end
        chk({tag, "_count"}, 64'(got), 64'(n));
        step();
        chk({tag, "_last_iready"}, 64'(i_ready), 64'd1);
        i_req = 1'b0;
        d_req = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          busy;
        bit          ok;
        int          rises;
        int          t_free, dec_c, exp_rdy, lat, streak_m;
        bit          in_flight, own_d, exp_err, exp_ir, exp_dr, exp_sreq, win_d;
        logic [31:0] exp_addr, exp_data, m_irdata, m_drdata;
        logic [36:0] exp_ctl;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sreq", 64'(s_req), 0);
        chk("rst_ctl", 64'({s_we, s_mask}), 0);
        chk("rst_addr", 64'(s_addr), 0);
        chk("rst_wdata", 64'(s_wdata), 0);
        chk("rst_ready", 64'({i_ready, d_ready, o_err}), 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        rst = 1'b1;
        step();

        // Single dbus read, slave answers in first BUSY cycle
        slave_lat  = 0;
        slave_data = 32'h1234_5678;
        drive_d(1'b0, 32'h0000_0100, 32'h0, 4'hf);
        step();
        chk("t1_sreq_n1", 64'(s_req), 1);
        chk("t1_saddr", 64'(s_addr), 64'h100);
        chk("t1_swe", 64'(s_we), 0);
        step();
        chk("t1_dready", 64'(d_ready), 1);
        chk("t1_drdata", 64'(d_rdata), 64'h1234_5678);
        chk("t1_sreq_n2", 64'(s_req), 0);
        chk("t1_iready", 64'(i_ready), 0);
        d_req = 1'b0;
        step();
        chk("t1_single_pulse", 64'({d_ready, i_ready}), 0);

        // Continuous contention
        slave_lat = 0;
        drive_i(1'b0, 32'h1000, 32'h0, 4'hf);
        drive_d(1'b0, 32'h2000, 32'h0, 4'hf);
        check_grants("t2", 10);

        // dbus write with 3-cycle slave delay
        slave_lat  = 3;
        slave_data = 32'h0BAD_F00D;
        drive_d(1'b1, 32'h10, 32'hA5A5_A5A5, 4'b0011);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t3_sreq%0d", k), 64'(s_req), 1);
            chk($sformatf("t3_fields%0d", k), {s_we, s_mask, s_addr[26:0], s_wdata},
                {1'b1, 4'b0011, 27'h10, 32'hA5A5_A5A5});
            chk($sformatf("t3_noready%0d", k), 64'(d_ready), 0);
        end
        step();
        chk("t3_dready", 64'(d_ready), 1);
        chk("t3_sreq_low", 64'(s_req), 0);
        d_req = 1'b0;
        step();
        chk("t3_single_pulse", 64'(d_ready), 0);

        // ibus timeout, then exact boundary answer, then a normal access
        slave_lat = -1;
        drive_i(1'b0, 32'h40, 32'h0, 4'hf);
        wait_ready(1'b0, busy, ok);
        chk("t4_done", 64'(ok), 1);
        chk("t4_busy_cycles", 64'(busy), 255);
        chk("t4_err", 64'(o_err), 1);
        chk("t4_rdata", 64'(i_rdata), 64'hDEAD_BEEF);
        chk("t4_dready", 64'(d_ready), 0);
        i_req = 1'b0;
        step();
        chk("t4_err_pulse", 64'(o_err), 0);
        slave_lat  = 254;
        slave_data = 32'h5555_AAAA;
        drive_i(1'b0, 32'h44, 32'h0, 4'hf);
        wait_ready(1'b0, busy, ok);
        chk("t4b_done", 64'(ok), 1);
        chk("t4b_busy_cycles", 64'(busy), 255);
        chk("t4b_err", 64'(o_err), 0);
        chk("t4b_rdata", 64'(i_rdata), 64'h5555_AAAA);
        i_req = 1'b0;
        step();
        slave_lat  = 1;
        slave_data = 32'h0000_0077;
        drive_i(1'b0, 32'h48, 32'h0, 4'hf);
        wait_ready(1'b0, busy, ok);
        chk("t4c_done", 64'(ok), 1);
        chk("t4c_err", 64'(o_err), 0);
        chk("t4c_rdata", 64'(i_rdata), 64'h77);
        i_req = 1'b0;
        step();

        // Asynchronous reset during BUSY after building a dbus streak of 3
        slave_lat  = 3;
        slave_data = 32'hCAFE_0000;
        drive_i(1'b0, 32'h1000, 32'h0, 4'hf);
        drive_d(1'b0, 32'h2000, 32'h0, 4'hf);
        rises = 0;
        for (int k = 0; k < 40 && rises < 3; k++) begin
            step();
            if (sreq_rise) rises++;
        end
        chk("t5_rises", 64'(rises), 3);
        #2 rst = 1'b0;
        #1;
        chk("t5_sreq_async", 64'(s_req), 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t5_quiet%0d", k), 64'({s_req, i_ready, d_ready, o_err}), 0);
        end
        rst = 1'b1;
        chk("t5_rdata_rst", {i_rdata, d_rdata}, 0);
        slave_lat = 0;
        check_grants("t5", 5);

        // Non-owner rdata holds
        slave_lat  = 1;
        slave_data = 32'h1;
        drive_i(1'b0, 32'h80, 32'h0, 4'hf);
        wait_ready(1'b0, busy, ok);
        chk("t6_i_done", 64'(ok), 1);
        chk("t6_irdata", 64'(i_rdata), 1);
        i_req = 1'b0;
        step();
        slave_data = 32'h2;
        drive_d(1'b0, 32'h84, 32'h0, 4'hf);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            step();
            chk($sformatf("t6_hold%0d", k), 64'(i_rdata), 1);
            if (d_ready) ok = 1'b1;
        end
        chk("t6_d_done", 64'(ok), 1);
        chk("t6_drdata", 64'(d_rdata), 2);
        d_req = 1'b0;
        step();
        step();

        // Random traffic against a transaction-level model
        noise     = 1'b1;
        t_free    = 0;
        in_flight = 1'b0;
        own_d     = 1'b0;
        streak_m  = 0;
        m_irdata  = 32'h1;
        m_drdata  = 32'h2;
        dec_c     = 0;
        exp_rdy   = 0;
        exp_err   = 1'b0;
        exp_addr  = '0;
        exp_ctl   = '0;
        exp_data  = '0;
        for (int k = 0; k < 3000; k++) begin
            step();
            exp_ir = in_flight && (cyc == exp_rdy) && !own_d;
            exp_dr = in_flight && (cyc == exp_rdy) && own_d;
            if (exp_ir) m_irdata = exp_data;
            if (exp_dr) m_drdata = exp_data;
            exp_sreq = in_flight && (cyc > dec_c) && (cyc < exp_rdy);
            chk("r_ready", 64'({i_ready, d_ready}), 64'({exp_ir, exp_dr}));
            chk("r_err", 64'(o_err), 64'((exp_ir | exp_dr) & exp_err));
            chk("r_rdata", {i_rdata, d_rdata}, {m_irdata, m_drdata});
            chk("r_sreq", 64'(s_req), 64'(exp_sreq));
            if (exp_sreq) begin
                chk("r_saddr", 64'(s_addr), 64'(exp_addr));
                chk("r_sctl", 64'({s_we, s_mask, s_wdata}), 64'(exp_ctl));
            end
            if (exp_ir | exp_dr) begin
                in_flight = 1'b0;
                t_free    = cyc + 1;
                if (exp_ir) i_req = 1'b0;
                if (exp_dr) d_req = 1'b0;
            end
            if (!i_req && !(in_flight && !own_d) && $urandom_range(0, 2) == 0)
                drive_i(1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom()));
            if (!d_req && !(in_flight && own_d) && $urandom_range(0, 2) == 0)
                drive_d(1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom()));
            // A granted master may withdraw; the access must still complete.
            if (in_flight && cyc > dec_c && $urandom_range(0, 7) == 0) begin
                if (own_d) d_req = 1'b0;
                else       i_req = 1'b0;
            end
            if (!in_flight && cyc >= t_free && (i_req || d_req)) begin
                win_d = d_req && !(i_req && streak_m == 4);
                if (win_d) streak_m = i_req ? ((streak_m == 4) ? 4 : streak_m + 1) : 0;
                else       streak_m = 0;
                own_d      = win_d;
                exp_addr   = win_d ? d_addr : i_addr;
                exp_ctl    = win_d ? {d_we, d_mask, d_wdata} : {i_we, i_mask, i_wdata};
                lat        = ($urandom_range(0, 99) == 0) ? -1 : int'($urandom_range(0, 3));
                slave_lat  = lat;
                slave_data = $urandom();
                exp_err    = (lat < 0);
                exp_data   = exp_err ? 32'hDEAD_BEEF : slave_data;
                exp_rdy    = exp_err ? cyc + 256 : cyc + lat + 2;
                dec_c      = cyc;
                in_flight  = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/membus_arbiter.md
Name: membus_arbiter

Overview:
- Two-master, one-slave arbiter that shares a single memory port between the core's instruction bus (ibus) and data bus (dbus).
- Sits between the core and the unified memory (pmem model or RAM). Replaces the current setup where each bus has its own direct read path.
- Registers each granted transaction and holds it stable on the slave port until the slave acknowledges.
- Returns the read data to the winning master with a one-cycle ready pulse. A bus-timeout watchdog ends hung accesses.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MW, 4, byte-mask width (DW/8).
- MAX_STREAK, 4, maximum consecutive dbus grants while ibus waits; after this many, ibus is forced a grant.
- TIMEOUT_CYC, 255, number of BUSY cycles without s_ready before the access is aborted.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req/i_we  in  1/1  ibus request / write enable.
- i_addr  in  AW  ibus address.
- i_wdata  in  DW  ibus write data.
- i_mask  in  MW  ibus byte mask.
- i_rdata  out  DW  ibus read data.
- i_ready  out  1  ibus completion pulse.
- d_req/d_we  in  1/1  dbus request / write enable.
- d_addr  in  AW  dbus address.
- d_wdata  in  DW  dbus write data.
- d_mask  in  MW  dbus byte mask.
- d_rdata  out  DW  dbus read data.
- d_ready  out  1  dbus completion pulse.
- s_req/s_we  out  1/1  slave request / write enable.
- s_addr  out  AW  slave address.
- s_wdata  out  DW  slave write data.
- s_mask  out  MW  slave byte mask.
- s_rdata  in  DW  slave read data.
- s_ready  in  1  slave acknowledge.
- o_err  out  1  timeout error pulse, coincident with the aborted master's ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - s_req, s_we, s_addr, s_wdata, s_mask = 0.
  - i_ready, d_ready, o_err = 0.
  - i_rdata, d_rdata = 0.
  - streak counter and timeout counter = 0.
  - An in-flight access is dropped immediately: s_req falls asynchronously and no ready is issued.
- States: IDLE, BUSY, RESP (encoded 2 bits).
- IDLE:
  - If d_req or i_req, pick a winner and latch its we/addr/wdata/mask into the s_* registers, record owner, go BUSY. s_req=1 from the next cycle.
  - Winner selection: d_req alone -> dbus; i_req alone -> ibus.
  - Both requesting: dbus wins unless streak==MAX_STREAK, in which case ibus wins.
- Streak counter:
  - Increments on a dbus grant made while i_req=1, saturating at MAX_STREAK.
  - Clears on any ibus grant, and on any dbus grant made while i_req=0.
- BUSY:
  - s_req=1; the s_* fields stay constant.
  - Timeout counter increments each BUSY cycle.
  - s_ready=1: capture s_rdata into the owner's rdata register, go RESP.
  - Counter reaches TIMEOUT_CYC-1 with s_ready=0: load ERR_DATA into the owner's rdata, set the err flag, go RESP.
  - s_ready takes precedence over timeout in the same cycle.
- RESP:
  - s_req=0; the owner's ready=1 for exactly one cycle; o_err=1 only if the err flag is set.
  - Non-owner rdata is unchanged.
  - Clear the timeout counter and err flag, go IDLE.
- Writes complete identically; the rdata register is loaded with s_rdata (don't-care for masters).
- Minimum latency: req sampled in cycle N (IDLE); s_req high in N+1; if s_ready in N+1, ready in N+2. Back-to-back grant is possible in N+3.
- Masters hold req and fields until their ready. A master dropping req mid-transaction does not cancel it; ready still pulses.
- i_ready and d_ready are never high in the same cycle. s_req never stays high after the s_ready cycle.
- rdata outputs hold their value until the owner's next completion.
- s_ready or s_rdata outside BUSY is ignored.

Test Plan:
- Single dbus read at 32'h0000_0100; slave answers s_ready in its first BUSY cycle with 32'h1234_5678 -> s_req high exactly 1 cycle, d_ready pulse 2 cycles after request, d_rdata=32'h1234_5678, i_ready stays 0.
- i_req and d_req held continuously, slave with 1-cycle latency -> grant order D,D,D,D,I,D,D,D,D,I...; ibus gets a grant after exactly MAX_STREAK=4 dbus grants.
- dbus write, addr 32'h10, wdata 32'hA5A5_A5A5, mask 4'b0011; slave delays s_ready 3 cycles -> s_addr, s_wdata and s_mask stable for all 4 BUSY cycles, s_we=1, single d_ready pulse.
- ibus read, slave never responds -> after 255 BUSY cycles i_ready=1 with o_err=1 and i_rdata=32'hDEAD_BEEF; next ibus access with a normal slave gives o_err=0.
- rst pulled low during BUSY -> s_req falls with no clock edge, no ready pulse; after release, rdata=0, streak=0, and a pending d_req is granted normally.
- ibus completes with rdata 32'h1 and dbus then completes with 32'h2 -> i_rdata stays 32'h1 throughout the dbus access.
